ad9361_samp_gate: RTL and testbench
===================================

// Module: ad9361_samp_gate
// PURPOSE
// - N-channel magnitude-gated sample filter between the AD9361 RX interface and downstream capture.
// - Per channel: computes an IQ magnitude estimate and averages it with a 2^L boxcar.
// - A hysteresis/hang-time gate FSM opens on the average; valid_out passes only samples inside the open gate.
// - Data is delayed by NUM_DELAY so samples from before the trigger point are still emitted.
// PARAMETERS
// NUM_CHANNELS        4   number of IQ channels
// DATA_WIDTH          12  signed I/Q sample width
// ABS_WIDTH           16  magnitude/average/threshold width (>= DATA_WIDTH)
// LOG2_FILTER_LENGTH  3   boxcar length = 2^L samples (L >= 1)
// NUM_DELAY           26  data/valid delay in clocks (>= 4)
// HOLD_WIDTH          16  hang-time counter width
// PORTS
// clk          in   1                  clock, all logic on rising edge
// rst          in   1                  async active-high reset
// en           in   1                  gate enable; 0 forces all gates CLOSED
// thr_on       in   ABS_WIDTH          open threshold (unsigned)
// thr_off      in   ABS_WIDTH          close threshold (unsigned, intended <= thr_on)
// hold_len     in   HOLD_WIDTH         hang time in clocks after avg falls to thr_off
// valid_in     in   NUM_CHANNELS       per-channel sample valid
// data_i_in    in   NUM_CHANNELS*DW    I samples, channel c at [c*DW +: DW]
// data_q_in    in   NUM_CHANNELS*DW    Q samples, same packing
// valid_out    out  NUM_CHANNELS       gated, delayed valid
// data_i_out   out  NUM_CHANNELS*DW    I delayed by NUM_DELAY, ungated
// data_q_out   out  NUM_CHANNELS*DW    Q delayed by NUM_DELAY, ungated
// gate_open    out  NUM_CHANNELS       1 while FSM is OPEN or HANG
// gate_rise    out  NUM_CHANNELS       1-clk pulse on CLOSED->OPEN
// BEHAVIOUR
// - Reset: all outputs 0; delay line, boxcar history, sums, hang counters cleared; FSM CLOSED.
// - Reset is honoured at any time, including with a gate open or hang running.
// - Magnitude (cycle t+1, registered): a=|I|, b=|Q|, mag = max(a,b) + (min(a,b)>>1).
//   - mag is zero-extended to ABS_WIDTH.
//   - An invalid slot (valid_in=0) contributes mag=0.
//   - |-2^(DW-1)| = 2^(DW-1), no wrap.
// - Boxcar (cycle t+2, registered): sum += mag_new - mag_oldest, width ABS_WIDTH+L, never overflows.
//   - avg = sum >> L (truncating). The window advances every clock.
// - FSM (state registered at t+3, one per channel, thresholds sampled each clock):
//   - CLOSED -> OPEN if avg > thr_on; gate_rise=1 for that clock.
//   - OPEN -> HANG if avg <= thr_off and hold_len != 0; counter loaded with hold_len.
//   - OPEN -> CLOSED if avg <= thr_off and hold_len == 0.
//   - HANG -> OPEN if avg > thr_on (counter discarded). Otherwise the counter decrements each clock.
//   - HANG -> CLOSED when the counter is 1 and avg <= thr_on. Gate is open for exactly hold_len HANG clocks.
//   - If thr_off > thr_on, OPEN takes priority when avg > thr_on. No illegal state.
//   - en=0: next state CLOSED, counter 0, no gate_rise. en 0->1 restarts from CLOSED.
//   - en does not affect the magnitude/boxcar path or the delay line.
// - Delay: data_*_out(t) = data_*_in(t-NUM_DELAY), ungated.
//   - valid_dly(t) = valid_in(t-NUM_DELAY), tracked per channel.
// - valid_out(t) = valid_dly(t) & gate_open(t), registered together with the data.
// - Channels are fully independent. Same-clock events on different channels do not interact.
// TESTING
// 1. Pre-trigger open: ch0 I=1000, Q=0, valid=1 from cycle t0; thr_on=300, thr_off=200, hold_len=0.
//    -> avg 375 at t0+4, gate_open/gate_rise at t0+5; first valid_out at t0+26 carrying the t0 sample.
// 2. Hang: after 1., drop to I=Q=0 with hold_len=10.
//    -> HANG entered when avg<=200; gate_open stays 1 for exactly 10 more clocks, then 0.
//    -> Restore I=1000 during HANG -> back to OPEN, no gate_rise.
// 3. Hysteresis: hold avg at 250 (between thr_off 200 and thr_on 300) from CLOSED -> stays CLOSED.
//    -> From OPEN at the same avg -> stays OPEN.
// 4. Extremes: I=-2048, Q=-2048 -> mag 3072, avg 3072; no wrap.
//    -> thr_on=3071 opens; thr_on=3072 does not.
// 5. Channel isolation: ch2 strong signal, ch0/1/3 zero.
//    -> only gate_open[2], valid_out[2] assert; all channels' data still delayed by 26 clocks.
// 6. Reset/enable mid-operation: assert rst while OPEN -> all outputs 0 same cycle.
//    -> After release, no valid_out until the gate reopens; en=0 while OPEN -> CLOSED next clock.

Source files
------------

// File: rtl/ad9361_samp_gate.sv
// Per-channel IQ magnitude gate for AD9361 RX samples: magnitude estimate, 2^L boxcar,
// hysteresis/hang-time FSM, with data delayed so pre-trigger samples are still emitted.
//
// state  | meaning
// CLOSED | gate shut, waiting for avg > thr_on
// OPEN   | gate open, avg has not yet fallen to thr_off
// HANG   | gate open, counting down hold_len clocks before closing
module ad9361_samp_gate #(
    parameter int NUM_CHANNELS       = 4,
    parameter int DATA_WIDTH         = 12,
    parameter int ABS_WIDTH          = 16,
    parameter int LOG2_FILTER_LENGTH = 3,
    parameter int NUM_DELAY          = 26,
    parameter int HOLD_WIDTH         = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic [ABS_WIDTH-1:0]               thr_on,
    input  logic [ABS_WIDTH-1:0]               thr_off,
    input  logic [HOLD_WIDTH-1:0]              hold_len,
    input  logic [NUM_CHANNELS-1:0]            valid_in,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_i_in,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_q_in,
    output logic [NUM_CHANNELS-1:0]            valid_out,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_i_out,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_q_out,
    output logic [NUM_CHANNELS-1:0]            gate_open,
    output logic [NUM_CHANNELS-1:0]            gate_rise
);

    localparam int FILT_LEN  = 1 << LOG2_FILTER_LENGTH;
    localparam int SUM_WIDTH = ABS_WIDTH + LOG2_FILTER_LENGTH;

    typedef enum logic [1:0] {
        ST_CLOSED = 2'd0,
        ST_OPEN   = 2'd1,
        ST_HANG   = 2'd2
    } gate_state_t;

    // Unsigned result is DATA_WIDTH wide so the most negative input maps to 2^(DW-1).
    function automatic logic [DATA_WIDTH-1:0] abs_val(input logic [DATA_WIDTH-1:0] x);
        return x[DATA_WIDTH-1] ? (~x + DATA_WIDTH'(1)) : x;
    endfunction

    logic [NUM_CHANNELS*DATA_WIDTH-1:0] dly_i [NUM_DELAY];
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] dly_q [NUM_DELAY];
    logic [NUM_CHANNELS-1:0]            dly_v [NUM_DELAY-1];
    logic [NUM_CHANNELS-1:0]            open_nxt;

    // valid_out pairs the delayed valid with the gate state of the same output cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_DELAY; k++) begin
                dly_i[k] <= '0;
                dly_q[k] <= '0;
            end
            for (int k = 0; k < NUM_DELAY-1; k++) dly_v[k] <= '0;
            valid_out <= '0;
        end else begin
            dly_i[0] <= data_i_in;
            dly_q[0] <= data_q_in;
            dly_v[0] <= valid_in;
            for (int k = 1; k < NUM_DELAY; k++) begin
                dly_i[k] <= dly_i[k-1];
                dly_q[k] <= dly_q[k-1];
            end
            for (int k = 1; k < NUM_DELAY-1; k++) dly_v[k] <= dly_v[k-1];
            valid_out <= dly_v[NUM_DELAY-2] & open_nxt;
        end
    end

    assign data_i_out = dly_i[NUM_DELAY-1];
    assign data_q_out = dly_q[NUM_DELAY-1];

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic [DATA_WIDTH-1:0] abs_i, abs_q, mag_max, mag_min, mag;
        logic [ABS_WIDTH-1:0]  mag_r;
        logic [ABS_WIDTH-1:0]  hist [FILT_LEN];
        logic [SUM_WIDTH-1:0]  sum_r;
        logic [ABS_WIDTH-1:0]  avg;
        gate_state_t           state, state_nxt;
        logic [HOLD_WIDTH-1:0] cnt, cnt_nxt;
        logic                  rise_r, rise_nxt;
        logic                  open_c, open_nxt_c;

        always_comb begin
            abs_i   = abs_val(data_i_in[c*DATA_WIDTH +: DATA_WIDTH]);
            abs_q   = abs_val(data_q_in[c*DATA_WIDTH +: DATA_WIDTH]);
            mag_max = (abs_i > abs_q) ? abs_i : abs_q;
            mag_min = (abs_i > abs_q) ? abs_q : abs_i;
            mag     = mag_max + (mag_min >> 1);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mag_r <= '0;
                sum_r <= '0;
                for (int k = 0; k < FILT_LEN; k++) hist[k] <= '0;
            end else begin
                mag_r   <= valid_in[c] ? ABS_WIDTH'(mag) : '0;
                hist[0] <= mag_r;
                for (int k = 1; k < FILT_LEN; k++) hist[k] <= hist[k-1];
                sum_r   <= sum_r + SUM_WIDTH'(mag_r) - SUM_WIDTH'(hist[FILT_LEN-1]);
            end
        end

        assign avg = sum_r[SUM_WIDTH-1:LOG2_FILTER_LENGTH];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state  <= ST_CLOSED;
                cnt    <= '0;
                rise_r <= 1'b0;
            end else begin
                state  <= state_nxt;
                cnt    <= cnt_nxt;
                rise_r <= rise_nxt;
            end
        end

        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            rise_nxt  = 1'b0;
            if (!en) begin
                state_nxt = ST_CLOSED;
                cnt_nxt   = '0;
            end else begin
                case (state)
                    ST_CLOSED: begin
                        if (avg > thr_on) begin
                            state_nxt = ST_OPEN;
                            rise_nxt  = 1'b1;
                        end
                    end
                    ST_OPEN: begin
                        // thr_on is tested first so a thr_off above thr_on cannot close a strong signal
                        if (!(avg > thr_on) && (avg <= thr_off)) begin
                            if (hold_len != '0) begin
                                state_nxt = ST_HANG;
                                cnt_nxt   = hold_len;
                            end else begin
                                state_nxt = ST_CLOSED;
                            end
                        end
                    end
                    ST_HANG: begin
                        if (avg > thr_on) begin
                            state_nxt = ST_OPEN;
                            cnt_nxt   = '0;
                        end else if (cnt == HOLD_WIDTH'(1)) begin
                            state_nxt = ST_CLOSED;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt - HOLD_WIDTH'(1);
                        end
                    end
                    default: begin
                        state_nxt = ST_CLOSED;
                        cnt_nxt   = '0;
                    end
                endcase
            end
        end

        always_comb begin
            open_c     = (state != ST_CLOSED);
            open_nxt_c = (state_nxt != ST_CLOSED);
        end

        assign gate_open[c] = open_c;
        assign gate_rise[c] = rise_r;
        assign open_nxt[c]  = open_nxt_c;
    end

endmodule

// File: tb/tb_ad9361_samp_gate.sv
// Directed bench for ad9361_samp_gate: steady-state threshold table plus hand-timed
// sequences for trigger latency, hang time, hysteresis, isolation, reset and enable.
module tb_ad9361_samp_gate;

    localparam int NC = 4;
    localparam int DW = 12;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0;
    logic [15:0]     thr_on = '0;
    logic [15:0]     thr_off = '0;
    logic [15:0]     hold_len = '0;
    logic [NC-1:0]   valid_in = '0;
    logic [NC*DW-1:0] data_i_in = '0;
    logic [NC*DW-1:0] data_q_in = '0;
    logic [NC-1:0]   valid_out;
    logic [NC*DW-1:0] data_i_out;
    logic [NC*DW-1:0] data_q_out;
    logic [NC-1:0]   gate_open;
    logic [NC-1:0]   gate_rise;

    int tests = 0;
    int fails = 0;

    ad9361_samp_gate dut (
        .clk(clk), .rst(rst), .en(en),
        .thr_on(thr_on), .thr_off(thr_off), .hold_len(hold_len),
        .valid_in(valid_in), .data_i_in(data_i_in), .data_q_in(data_q_in),
        .valid_out(valid_out), .data_i_out(data_i_out), .data_q_out(data_q_out),
        .gate_open(gate_open), .gate_rise(gate_rise)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic               valid;
        logic signed [11:0] i;
        logic signed [11:0] q;
        logic [15:0]        thr;
        logic               exp_open;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_ch(input int c, input logic v, input logic signed [11:0] i,
                          input logic signed [11:0] q);
        valid_in[c]           = v;
        data_i_in[c*DW +: DW] = i;
        data_q_in[c*DW +: DW] = q;
    endtask

    task automatic do_reset();
        valid_in  = '0;
        data_i_in = '0;
        data_q_in = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1,  12'sd1000,     12'sd0,  16'd300, 1'b1};
        vecs[1]  = '{1'b1,  12'sd1000,     12'sd0, 16'd1000, 1'b0};
        vecs[2]  = '{1'b1,  12'sd1000,     12'sd0,  16'd999, 1'b1};
        vecs[3]  = '{1'b1, -12'sd2048, -12'sd2048, 16'd3071, 1'b1};
        vecs[4]  = '{1'b1, -12'sd2048, -12'sd2048, 16'd3072, 1'b0};
        vecs[5]  = '{1'b1,  12'sd2047, -12'sd2048, 16'd3070, 1'b1};
        vecs[6]  = '{1'b1,  12'sd2047, -12'sd2048, 16'd3071, 1'b0};
        vecs[7]  = '{1'b1,     12'sd0,  -12'sd600,  16'd599, 1'b1};
        vecs[8]  = '{1'b1,   12'sd300,   12'sd400,  16'd549, 1'b1};
        vecs[9]  = '{1'b1,   12'sd300,   12'sd400,  16'd550, 1'b0};
        vecs[10] = '{1'b0,  12'sd1000,     12'sd0,  16'd300, 1'b0};
        vecs[11] = '{1'b1,   12'sd250,     12'sd0,  16'd300, 1'b0};

        en = 1'b1;
        do_reset();
        check("reset_valid_out", valid_out, 0);
        check("reset_gate_open", gate_open, 0);
        check("reset_gate_rise", gate_rise, 0);
        check("reset_data_i", data_i_out, 0);

        // steady-state magnitude/threshold table on channel 0
        for (int n = 0; n < 12; n++) begin
            do_reset();
            thr_on = vecs[n].thr; thr_off = '0; hold_len = '0;
            set_ch(0, vecs[n].valid, vecs[n].i, vecs[n].q);
            repeat (12) tick();
            check($sformatf("table%0d_open", n), gate_open, {3'b000, vecs[n].exp_open});
        end

        // pre-trigger open: Q carries the sample index so the delayed sample is identifiable
        do_reset();
        thr_on = 16'd300; thr_off = 16'd200; hold_len = '0;
        for (int k = 1; k <= 30; k++) begin
            set_ch(0, 1'b1, 12'sd1000, 12'(k-1));
            tick();
            check($sformatf("trig_open_k%0d", k), gate_open[0], k >= 5);
            check($sformatf("trig_rise_k%0d", k), gate_rise[0], k == 5);
            check($sformatf("trig_vout_k%0d", k), valid_out[0], k >= 26);
            if (k >= 26) begin
                check($sformatf("trig_dq_k%0d", k), data_q_out[11:0], 12'(k-26));
                check($sformatf("trig_di_k%0d", k), data_i_out[11:0], 12'd1000);
            end else if (k == 25) begin
                check("trig_di_pre", data_i_out[11:0], 0);
            end
        end

        // hang: avg reaches 125 seven clocks after the drop, so HANG covers k=9..18
        set_ch(0, 1'b1, 12'sd1000, 12'sd0);
        repeat (10) tick();
        hold_len = 16'd10;
        set_ch(0, 1'b1, 12'sd0, 12'sd0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("hang_open_k%0d", k), gate_open[0], k <= 18);
            check($sformatf("hang_vout_k%0d", k), valid_out[0], k <= 18);
            check($sformatf("hang_rise_k%0d", k), gate_rise[0], 0);
        end

        // restore during HANG: reopens at k=15, before the hang would expire at k=19
        set_ch(0, 1'b1, 12'sd1000, 12'sd0);
        repeat (12) tick();
        set_ch(0, 1'b1, 12'sd0, 12'sd0);
        for (int k = 1; k <= 25; k++) begin
            tick();
            check($sformatf("rehang_open_k%0d", k), gate_open[0], 1);
            check($sformatf("rehang_rise_k%0d", k), gate_rise[0], 0);
            if (k == 10) set_ch(0, 1'b1, 12'sd1000, 12'sd0);
        end

        // hysteresis: avg 250 sits between thresholds
        do_reset();
        thr_on = 16'd300; thr_off = 16'd200; hold_len = '0;
        set_ch(0, 1'b1, 12'sd250, 12'sd0);
        repeat (14) tick();
        check("hyst_closed", gate_open[0], 0);
        set_ch(0, 1'b1, 12'sd1000, 12'sd0);
        repeat (10) tick();
        check("hyst_opened", gate_open[0], 1);
        set_ch(0, 1'b1, 12'sd250, 12'sd0);
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k >= 11) check($sformatf("hyst_stay_k%0d", k), gate_open[0], 1);
        end

        // channel isolation with distinct data per channel
        do_reset();
        thr_on = 16'd300; thr_off = 16'd200; hold_len = '0;
        set_ch(0, 1'b0, 12'sd1500, 12'sd0);
        set_ch(1, 1'b1, 12'sd50, 12'sd0);
        set_ch(2, 1'b1, 12'sd1000, -12'sd300);
        set_ch(3, 1'b1, 12'sd0, -12'sd60);
        for (int k = 1; k <= 26; k++) begin
            tick();
            if (k == 10) check("iso_open", gate_open, 4'b0100);
            if (k == 25) begin
                check("iso_di_pre", data_i_out, 0);
                check("iso_vout_pre", valid_out, 0);
            end
            if (k == 26) begin
                check("iso_di", data_i_out, data_i_in);
                check("iso_dq", data_q_out, data_q_in);
                check("iso_vout", valid_out, 4'b0100);
            end
        end

        // asynchronous reset while ch2 is open
        #2;
        rst = 1'b1;
        #1;
        check("arst_vout", valid_out, 0);
        check("arst_open", gate_open, 0);
        check("arst_rise", gate_rise, 0);
        check("arst_di", data_i_out, 0);
        check("arst_dq", data_q_out, 0);
        tick();
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            tick();
            check($sformatf("rel_open_k%0d", k), gate_open[2], k >= 5);
            check($sformatf("rel_rise_k%0d", k), gate_rise[2], k == 5);
            check($sformatf("rel_vout_k%0d", k), valid_out, (k == 26) ? 4'b0100 : 4'b0000);
        end

        // enable drop and restart
        en = 1'b0;
        tick();
        check("en_off_open", gate_open, 0);
        check("en_off_vout", valid_out, 0);
        check("en_off_rise", gate_rise, 0);
        en = 1'b1;
        tick();
        check("en_on_open", gate_open, 4'b0100);
        check("en_on_rise", gate_rise, 4'b0100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
